regbank_arbiter: RTL

- Round-robin arbiter and sequencer that shares one bank of 8-bit write-enabled registers between NREQ requesters.
- Each requester issues single read or write transactions over a req/gnt/ack handshake.
- The block generates the per-register write enables and captures read data.
- It is the control layer above the 8-bit enable registers: no requester drives a register's wr_en directly.

---
 rtl/regbank_pkg.sv | 28 ++
 rtl/regbank_arbiter_if.sv | 29 ++
 rtl/regbank_storage.sv | 37 +++
 rtl/regbank_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank arbiter: state encoding, data width
// and the round-robin winner search.
package regbank_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // First requester with req set, searching upward from last+1 (mod nreq);
    // the just-served requester is considered last. Caller guarantees |req.
    function automatic logic [1:0] rr_next(input logic [3:0]  req,
                                           input logic [1:0]  last,
                                           input int unsigned nreq);
        logic [1:0]  win;
        int unsigned idx;
        win = last;
        for (int unsigned k = nreq; k >= 1; k--) begin
            idx = (32'(last) + k) % nreq;
            if (req[idx[1:0]]) win = idx[1:0];
        end
        return win;
    endfunction

endpackage

// File: rtl/regbank_arbiter_if.sv
// Requester-side bus of the register-bank arbiter: per-requester request
// fields, one-hot grant/ack, shared read data and live register contents.
interface regbank_arbiter_if #(
    parameter int NREQ = 2,
    parameter int NREG = 4,
    parameter int AW   = 2
);
    import regbank_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [NREG*DW-1:0] reg_q;

    modport master (
        output req, we, addr, wdata,
        input  gnt, ack, rdata, reg_q
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, ack, rdata, reg_q
    );

endinterface

// File: rtl/regbank_storage.sv
// Bank of NREG 8-bit write-enable registers sharing one data input; at most
// one bit of wr_en is expected high per cycle.
module regbank_storage
    import regbank_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREG-1:0]     wr_en,
    input  logic [DW-1:0]       wdata,
    output logic [NREG*DW-1:0]  reg_q
);

    logic [NREG*DW-1:0] bank_d;
    logic [NREG*DW-1:0] bank_q;

    // NOTE: next-state starts as a copy of the current state so every path
    // assigns bank_d and no latch is inferred.
    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_en[i]) bank_d[i*DW +: DW] = wdata;
        end
    end

    // NOTE: the bank is small flop storage with a defined power-up value the
    // datapath relies on, so it is reset like any control flop (not a RAM).
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) bank_q <= '0;
        else       bank_q <= bank_d;
    end

    assign reg_q = bank_q;

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter and IDLE/XFER/ACK sequencer sharing one register bank
// between NREQ requesters; one transaction every three cycles.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic               clock,
    input  logic               reset,
    regbank_arbiter_if.slave   bus
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        win_q, win_d;
    logic              hold_we_q, hold_we_d;
    logic [AW-1:0]     hold_addr_q, hold_addr_d;
    logic [DW-1:0]     hold_wdata_q, hold_wdata_d;

    logic [NREG-1:0]   wr_en;
    logic [DW-1:0]     sel_data;
    logic [1:0]        pick;

    assign pick = rr_next(4'(bus.req), last_q, NREQ);

    // Out-of-range addresses match no register and therefore read as zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (hold_addr_q == AW'(i)) sel_data = bus.reg_q[i*DW +: DW];
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ack_d        = ack_q;
        rdata_d      = rdata_q;
        last_d       = last_q;
        win_d        = win_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        wr_en        = '0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick == 2'(i)) begin
                            gnt_d        = '0;
                            gnt_d[i]     = 1'b1;
                            hold_we_d    = bus.we[i];
                            hold_addr_d  = bus.addr[i*AW +: AW];
                            hold_wdata_d = bus.wdata[i*DW +: DW];
                        end
                    end
                    win_d   = pick;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Gating with reset keeps an aborted write out of the bank.
                for (int i = 0; i < NREG; i++) begin
                    if (hold_addr_q == AW'(i)) wr_en[i] = hold_we_q & ~reset;
                end
                if (!hold_we_q) rdata_d = sel_data;
                ack_d   = gnt_q;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                gnt_d   = '0;
                ack_d   = '0;
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            last_q       <= 2'(NREQ - 1);
            win_q        <= '0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            last_q       <= last_d;
            win_q        <= win_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    regbank_storage #(.NREG(NREG)) u_storage (
        .clock (clock),
        .reset (reset),
        .wr_en (wr_en),
        .wdata (hold_wdata_q),
        .reg_q (bus.reg_q)
    );

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule
